// File: rtl/imem_arb_pkg.sv
// Purpose: shared state encoding, owner type and response constant for the imem AXI-lite arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
//
// Contents:
//   arb_state_t - 3-bit FSM state type with legacy-style localparam encodings
//   owner_t     - which requester owns the in-flight transaction
//   RESP_OKAY   - value of m_bresp / m_rresp that means success
package imem_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 3'd0;
  localparam arb_state_t ST_RD_A  = 3'd1;
  localparam arb_state_t ST_RD_D  = 3'd2;
  localparam arb_state_t ST_WR_AW = 3'd3;
  localparam arb_state_t ST_WR_B  = 3'd4;
  localparam arb_state_t ST_RSP   = 3'd5;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LOAD  = 1'b1
  } owner_t;

  localparam logic RESP_OKAY = 1'b1;

endpackage

// File: rtl/imem_axil_arbiter.sv
// Purpose: arbitrates a fetch reader and a loader (read/write) onto one AXI-lite master, one transaction at a time.
// Latency: 3 cycles from request sampled in IDLE to the done pulse with an always-ready slave.
// Backpressure: master valids hold with stable payload until handshake; requesters wait on their done pulse.
//
// Ports:
//   clk, reset          - single clock, synchronous active-low reset
//   f_req/f_addr/f_done - fetch read requester and its completion pulse
//   l_req/l_we/l_addr/l_wdata/l_wstrb/l_done - loader requester and its completion pulse
//   rsp_rdata, rsp_err  - response payload, meaningful only alongside a done pulse
//   m_aw*/m_w*/m_b*     - AXI-lite write address, write data and write response channels
//   m_ar*/m_r*          - AXI-lite read address and read data channels
// Build option: define IMEM_ARB_RR_EN for round-robin grant on simultaneous
// requests; otherwise the loader always wins over fetch.
module imem_axil_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  // fetch requester
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  // loader requester
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  input  logic [3:0]        l_wstrb,
  output logic              l_done,
  // shared response
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  // AXI-lite write address
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  // AXI-lite write data
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  // AXI-lite write response
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic              m_bresp,
  // AXI-lite read address
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  // AXI-lite read data
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [31:0]       m_rdata,
  input  logic              m_rresp
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic grant_load;
  logic aw_ok;
  logic w_ok;

  // Grant selection. owner_q always holds the most recent owner (reset to
  // fetch), so it doubles as the round-robin pointer.
  always_comb begin
    grant_load = 1'b0;
    if (l_req && !f_req) begin
      grant_load = 1'b1;
    end else if (l_req && f_req) begin
`ifdef IMEM_ARB_RR_EN
      grant_load = (owner_q == OWN_FETCH);
`else
      grant_load = 1'b1;
`endif
    end
  end

  // A write channel counts as done once it has handshaken in this cycle or
  // an earlier one; AW and W may complete in either order.
  assign aw_ok = aw_done_q | m_awready;
  assign w_ok  = w_done_q  | m_wready;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (f_req || l_req) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (grant_load) begin
            owner_d = OWN_LOAD;
            addr_d  = l_addr;
            wdata_d = l_wdata;
            wstrb_d = l_wstrb;
            state_d = l_we ? ST_WR_AW : ST_RD_A;
          end else begin
            owner_d = OWN_FETCH;
            addr_d  = f_addr;
            state_d = ST_RD_A;
          end
        end
      end
      ST_RD_A: begin
        if (m_arready) state_d = ST_RD_D;
      end
      ST_RD_D: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          err_d   = (m_rresp != RESP_OKAY);
          state_d = ST_RSP;
        end
      end
      ST_WR_AW: begin
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        if (m_bvalid) begin
          err_d   = (m_bresp != RESP_OKAY);
          state_d = ST_RSP;
        end
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_FETCH;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // All outputs decode from registers only, so no request-to-master
  // combinational path exists.
  assign m_arvalid = (state_q == ST_RD_A);
  assign m_araddr  = addr_q;
  assign m_rready  = (state_q == ST_RD_D);

  assign m_awvalid = (state_q == ST_WR_AW) && !aw_done_q;
  assign m_awaddr  = addr_q;
  assign m_wvalid  = (state_q == ST_WR_AW) && !w_done_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = (state_q == ST_WR_B);

  assign f_done    = (state_q == ST_RSP) && (owner_q == OWN_FETCH);
  assign l_done    = (state_q == ST_RSP) && (owner_q == OWN_LOAD);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = (state_q == ST_RSP) && err_q;

endmodule

// File: tb/tb_imem_axil_arbiter.sv
// Purpose: self-checking bench for imem_axil_arbiter against a byte-level AXI-lite slave and a word-level reference memory.
// Latency: expected done latency derived from slave ready/valid delays.
// Backpressure: slave inserts configurable ready and response delays on every channel.
module tb_imem_axil_arbiter;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [11:0] f_addr;
  logic        f_done;
  logic        l_req;
  logic        l_we;
  logic [11:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_wstrb;
  logic        l_done;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_awvalid, m_awready;
  logic [11:0] m_awaddr;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready, m_bresp;
  logic        m_arvalid, m_arready;
  logic [11:0] m_araddr;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic        m_rresp;

  imem_axil_arbiter #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_wstrb(l_wstrb), .l_done(l_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // slave configuration and observation
  int  ar_dly, r_dly, aw_dly, w_dly, b_dly;
  bit  rresp_ok, bresp_ok;
  int  ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int  ar_hs, aw_hs, w_hs, ar_vcyc, viol;
  bit  r_pend, b_pend, aw_got, w_got, rst_edge;
  logic [11:0] rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        s_arv, s_rr, s_awv, s_wv, s_br;
  logic [11:0] s_araddr, s_awaddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;

  logic [7:0]  smem [0:4095];   // slave storage, byte addressed
  logic [31:0] rmem [0:1023];   // reference model, word addressed
  bit          exp_load [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = 32'd0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    rmem[a[11:2]] = (rmem[a[11:2]] & ~mask) | (d & mask);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {56'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, f_done, l_done, rsp_err}, 64'd0);
  endtask

  // AXI-lite slave: samples handshakes at the edge, drives new values 1 unit later.
  initial begin
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; ar_vcyc = 0; viol = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    s_arv = 0; s_rr = 0; s_awv = 0; s_wv = 0; s_br = 0;
    s_araddr = 0; s_awaddr = 0; s_wdata = 0; s_wstrb = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
    forever begin
      @(posedge clk);
      rst_edge = !reset;
      if (!reset) begin
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      end else begin
        if (s_rr && m_rvalid) r_pend = 0;
        if (s_arv && m_arready) begin ar_hs++; rd_addr = s_araddr; r_pend = 1; r_wait = 0; end
        if (s_awv && m_awready) begin aw_hs++; wr_addr = s_awaddr; aw_got = 1; end
        if (s_wv && m_wready) begin w_hs++; wr_data = s_wdata; wr_strb = s_wstrb; w_got = 1; end
        if (s_br && m_bvalid) b_pend = 0;
        if (aw_got && w_got) begin
          if (bresp_ok)
            for (int b = 0; b < 4; b++)
              if (wr_strb[b]) smem[{wr_addr[11:2], 2'(b)}] = wr_data[8*b +: 8];
          b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0;
        end
      end
      #1;
      // a valid must not drop or change payload before its handshake
      if (!rst_edge && s_arv && !m_arready && (!m_arvalid || m_araddr !== s_araddr)) viol++;
      if (!rst_edge && s_awv && !m_awready && (!m_awvalid || m_awaddr !== s_awaddr)) viol++;
      if (!rst_edge && s_wv && !m_wready && (!m_wvalid || m_wdata !== s_wdata || m_wstrb !== s_wstrb)) viol++;
      if (m_arvalid) begin ar_vcyc++; m_arready = (ar_wait >= ar_dly); ar_wait++; end
      else begin m_arready = 0; ar_wait = 0; end
      if (m_awvalid) begin m_awready = (aw_wait >= aw_dly); aw_wait++; end
      else begin m_awready = 0; aw_wait = 0; end
      if (m_wvalid) begin m_wready = (w_wait >= w_dly); w_wait++; end
      else begin m_wready = 0; w_wait = 0; end
      if (r_pend) begin
        m_rvalid = (r_wait >= r_dly);
        m_rresp  = rresp_ok;
        m_rdata  = {smem[{rd_addr[11:2], 2'd3}], smem[{rd_addr[11:2], 2'd2}],
                    smem[{rd_addr[11:2], 2'd1}], smem[{rd_addr[11:2], 2'd0}]};
        r_wait++;
      end else begin
        m_rvalid = 0; m_rdata = 0;
      end
      if (b_pend) begin m_bvalid = (b_wait >= b_dly); m_bresp = bresp_ok; b_wait++; end
      else m_bvalid = 0;
      s_arv = m_arvalid; s_araddr = m_araddr; s_rr = m_rready;
      s_awv = m_awvalid; s_awaddr = m_awaddr;
      s_wv = m_wvalid; s_wdata = m_wdata; s_wstrb = m_wstrb; s_br = m_bready;
    end
  end

  // One single-requester transaction; expectations come from rmem and the delays.
  task automatic txn(input string tag, input bit is_load, input bit we, input logic [11:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input int ad, input int rd, input int awd, input int wd, input int bd,
                     input bit rok, input bit bok);
    int lat, exp_lat, aw0, w0, ar0;
    bit got, is_wr;
    logic [31:0] exp_d;
    is_wr = is_load && we;
    ar_dly = ad; r_dly = rd; aw_dly = awd; w_dly = wd; b_dly = bd;
    rresp_ok = rok; bresp_ok = bok;
    aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
    exp_d = rmem[a[11:2]];
    if (is_wr) exp_lat = 3 + ((awd > wd) ? awd : wd) + bd;
    else       exp_lat = 3 + ad + rd;
    if (is_wr && bok) ref_write(a, d, s);
    if (is_load) begin l_req = 1; l_we = we; l_addr = a; l_wdata = d; l_wstrb = s; end
    else begin f_req = 1; f_addr = a; end
    lat = 0; got = 0;
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      got = f_done || l_done;
    end
    chk({tag, "_done"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_owner"}, {62'd0, l_done, f_done}, is_load ? 64'd2 : 64'd1);
      chk({tag, "_err"}, 64'(rsp_err), is_wr ? 64'(!bok) : 64'(!rok));
      if (!is_wr && rok) chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_d));
    end
    f_req = 0; l_req = 0;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {62'd0, l_done, f_done}, 64'd0);
    if (is_wr) begin
      chk({tag, "_aw_cnt"}, 64'(aw_hs - aw0), 64'd1);
      chk({tag, "_w_cnt"}, 64'(w_hs - w0), 64'd1);
      chk({tag, "_awaddr"}, 64'(wr_addr), 64'(a));
      chk({tag, "_wdata"}, 64'(wr_data), 64'(d));
      chk({tag, "_wstrb"}, 64'(wr_strb), 64'(s));
    end else begin
      chk({tag, "_ar_cnt"}, 64'(ar_hs - ar0), 64'd1);
      chk({tag, "_araddr"}, 64'(rd_addr), 64'(a));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, n, lat;
    bit got, ld, we;
    logic [11:0] a;

`ifdef IMEM_ARB_RR_EN
    exp_load[0] = 1; exp_load[1] = 0; exp_load[2] = 1; exp_load[3] = 0;
`else
    exp_load[0] = 1; exp_load[1] = 1; exp_load[2] = 1; exp_load[3] = 1;
`endif
    for (int i = 0; i < 4096; i++) smem[i] = 8'((i * 37 + 5) & 255);
    for (int w = 0; w < 1024; w++)
      rmem[w] = {8'(((4*w+3) * 37 + 5) & 255), 8'(((4*w+2) * 37 + 5) & 255),
                 8'(((4*w+1) * 37 + 5) & 255), 8'(((4*w) * 37 + 5) & 255)};
    smem[12'h010] = 8'hEF; smem[12'h011] = 8'hBE; smem[12'h012] = 8'hAD; smem[12'h013] = 8'hDE;
    rmem[4] = 32'hDEADBEEF;

    reset = 0; f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_wstrb = 0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0; rresp_ok = 1; bresp_ok = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset_outputs");
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    reset = 1;
    @(posedge clk); #1;
    chk_quiet("idle_no_req");

    // fetch returning DEADBEEF with an always-ready slave
    txn("fetch010", 0, 0, 12'h010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1, 1);
    // loader write, W accepted two cycles after AW, then read it back
    txn("ldwr020", 1, 1, 12'h020, 32'h12345678, 4'b0011, 0, 0, 0, 2, 0, 1, 1);
    txn("ldrd020", 1, 0, 12'h020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1, 1);
    txn("ldwr_fast", 1, 1, 12'h024, 32'hA5A5_5A5A, 4'b1111, 0, 0, 0, 0, 0, 1, 1);
    txn("ldwr_awlate", 1, 1, 12'h028, 32'hCAFE_F00D, 4'b1100, 0, 0, 3, 0, 1, 1, 0);
    // read error with arvalid held against five unready cycles
    v0 = ar_vcyc;
    txn("rd_err", 0, 0, 12'h030, 32'h0, 4'h0, 5, 0, 0, 0, 0, 0, 1);
    chk("ar_hold_cycles", 64'(ar_vcyc - v0), 64'd6);
    chk("ar_stable", 64'(viol), 64'd0);

    // reset while waiting in the read-data phase
    ar_dly = 0; r_dly = 20; rresp_ok = 1;
    f_req = 1; f_addr = 12'h040;
    n = 0;
    while (!m_rready && n < 20) begin @(posedge clk); #1; n++; end
    chk("reach_rd_d", 64'(m_rready), 64'd1);
    reset = 0; f_req = 0;
    @(posedge clk); #1;
    chk_quiet("midrst_outputs");
    chk("midrst_rdata", 64'(rsp_rdata), 64'd0);
    reset = 1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (f_done || l_done || m_arvalid || m_awvalid || m_wvalid) n++;
    end
    chk("midrst_no_done", 64'(n), 64'd0);

    // simultaneous requests held across four transactions
    ar_dly = 0; r_dly = 0;
    f_req = 1; f_addr = 12'h100; l_req = 1; l_we = 0; l_addr = 12'h104;
    for (int k = 0; k < 4; k++) begin
      got = 0; lat = 0;
      while (!got && lat < 50) begin @(posedge clk); #1; lat++; got = f_done || l_done; end
      chk($sformatf("arb_done%0d", k), 64'(got), 64'd1);
      chk($sformatf("arb_owner%0d", k), {62'd0, l_done, f_done}, exp_load[k] ? 64'd2 : 64'd1);
      chk($sformatf("arb_rdata%0d", k), 64'(rsp_rdata), exp_load[k] ? 64'(rmem[65]) : 64'(rmem[64]));
    end
    f_req = 0; l_req = 0;
    @(posedge clk); #1;
    chk_quiet("arb_end");

    // randomized single-requester traffic over a small window so reads hit writes
    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom_range(0, 1));
      we = ld && (1'($urandom_range(0, 1)));
      a  = 12'($urandom_range(0, 15) * 4);
      txn($sformatf("rnd%0d", i), ld, we, a, $urandom, 4'($urandom_range(1, 15)),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
    end
    chk("protocol_viol", 64'(viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_axil_arbiter.md
IMEM_AXIL_ARBITER -- requirements
Module: imem_axil_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width of all address ports; data width is fixed at 32.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port f_req  input  1  fetch read request, held until f_done.
REQ-005 SHALL have port f_addr  input  ADDR_W  fetch address, stable while f_req.
REQ-006 SHALL have port f_done  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port l_req  input  1  loader request, held until l_done.
REQ-008 SHALL have port l_we  input  1  loader direction: 1 = write, 0 = read.
REQ-009 SHALL have port l_addr  input  ADDR_W  loader address.
REQ-010 SHALL have port l_wdata  input  32  loader write data.
REQ-011 SHALL have port l_wstrb  input  4  loader byte strobes.
REQ-012 SHALL have port l_done  output  1  one-cycle loader completion pulse.
REQ-013 SHALL have port rsp_rdata  output  32  read data; valid only while f_done or l_done (read).
REQ-014 SHALL have port rsp_err  output  1  error flag; valid only with a done pulse.
REQ-015 SHALL have AXI-lite master ports m_awvalid out 1, m_awready in 1, m_awaddr out ADDR_W: write address channel.
REQ-016 SHALL have ports m_wvalid out 1, m_wready in 1, m_wdata out 32, m_wstrb out 4: write data channel.
REQ-017 SHALL have ports m_bvalid in 1, m_bready out 1, m_bresp in 1: write response; 1 = OKAY.
REQ-018 SHALL have ports m_arvalid out 1, m_arready in 1, m_araddr out ADDR_W: read address channel.
REQ-019 SHALL have ports m_rvalid in 1, m_rready out 1, m_rdata in 32, m_rresp in 1: read data; 1 = OKAY.

Function
REQ-020 SHALL implement FSM IDLE, RD_A, RD_D, WR_AW, WR_B, RSP; exactly one transaction is in flight at a time.
REQ-021 In IDLE SHALL grant one requester, latch its address/data/strobe/direction and owner, and go to RD_A (fetch or l_we=0) or WR_AW (l_we=1); with no request it stays in IDLE.
REQ-022 RD_A: m_arvalid=1 with latched address, to RD_D on m_arready; RD_D: m_rready=1, capture m_rdata and ~m_rresp on m_rvalid, then to RSP.
REQ-023 WR_AW: m_awvalid and m_wvalid both assert; each deasserts after its own handshake, in any order or together; both complete -> WR_B.
REQ-024 WR_B: m_bready=1, capture ~m_bresp on m_bvalid, then to RSP.
REQ-025 RSP: pulse the owner's done for exactly one cycle with rsp_rdata/rsp_err; return to IDLE; requester deasserts req during RSP.
REQ-026 Latency with an always-ready slave SHALL be 3 cycles from req sampled in IDLE to done, for both read and write.
REQ-027 Master valids SHALL stay high and payloads stable until handshake; requester req changes outside IDLE SHALL be ignored.

Reset
REQ-028 While reset=0 at a clock edge: FSM -> IDLE; all m_*valid, m_*ready, f_done, l_done, rsp_err = 0; rsp_rdata = 0; in-flight transaction abandoned without done.

Configuration
REQ-029 With IMEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin (pointer to last owner, reset to fetch so the loader wins first); without it, the loader SHALL always win over fetch.

Structure
REQ-030 Package imem_arb_pkg SHALL hold arb_state_t, owner enum (OWN_FETCH, OWN_LOAD) and RESP_OKAY = 1'b1; grant logic stays inline, with no sub-module.

Verification
REQ-031 Fetch of 12'h010 with a ready slave returning 32'hDEADBEEF/rresp=1 -> f_done in the 3rd cycle, rsp_rdata=32'hDEADBEEF, rsp_err=0.
REQ-032 Loader write 12'h020, 32'h12345678, strb 4'b0011, with wready 2 cycles after awready -> AW and W each accepted once, l_done after bvalid, rsp_err=0.
REQ-033 f_req and l_req asserted together, held across 4 transactions -> without macro: L,L,L,L; with IMEM_ARB_RR_EN: L,F,L,F.
REQ-034 Read with m_rresp=0 -> done with rsp_err=1; arvalid held 5 cycles against an unready slave with m_araddr stable.
REQ-035 reset=0 asserted in RD_D, then released -> all outputs 0 the next cycle, no done, the next request served normally.
